// File: rtl/scan_mux_if.sv
// Bundle of the scan multiplexer's control, data and status signals.
// The master drives selection and channel data; the slave returns the registered sample.
interface scan_mux_if #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic               en;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [DWELL_W-1:0] dwell;
    logic [N*W-1:0]     din;
    logic [W-1:0]       dout;
    logic [SW-1:0]      ch;
    logic               valid;
    logic               wrap;

    modport master (
        output en, mode, sel, dwell, din,
        input  dout, ch, valid, wrap
    );

    modport slave (
        input  en, mode, sel, dwell, din,
        output dout, ch, valid, wrap
    );
endinterface

// File: rtl/scan_mux.sv
// N-channel registered multiplexer with manual select or auto-scan rotation.
// dout, ch, valid and wrap all come straight from flops, one cycle after sampling.
module scan_mux #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    scan_mux_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [W-1:0]       chan [N];
    logic [SW-1:0]      c_sel;
    logic               in_range;
    logic [W-1:0]       data_sel;
    logic               last_ch;
    logic               advance;

    logic [W-1:0]       dout_reg;
    logic [SW-1:0]      ch_reg;
    logic               valid_reg;
    logic               wrap_reg;
    logic [SW-1:0]      ptr_reg;
    logic [DWELL_W-1:0] cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = bus.din[gi*W +: W];
        end
    endgenerate

    assign c_sel = bus.mode ? ptr_reg : bus.sel;

    // Only a non-power-of-2 channel count leaves select codes with no channel.
    generate
        if ((1 << SW) == N) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            assign in_range = (c_sel < SW'(N));
        end
    endgenerate

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (c_sel == SW'(k)) begin
                data_sel = chan[k];
            end
        end
    end

    // >= rather than == so a dwell lowered below the running count still advances.
    assign advance = (cnt_reg >= bus.dwell);
    assign last_ch = (ptr_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else if (!bus.en) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            if (in_range) begin
                dout_reg  <= data_sel;
                ch_reg    <= c_sel;
                valid_reg <= 1'b1;
            end else begin
                dout_reg  <= '0;
                valid_reg <= 1'b0;
            end

            if (bus.mode) begin
                if (advance) begin
                    cnt_reg  <= '0;
                    ptr_reg  <= last_ch ? '0 : ptr_reg + SW'(1);
                    wrap_reg <= last_ch;
                end else begin
                    cnt_reg  <= cnt_reg + DWELL_W'(1);
                    wrap_reg <= 1'b0;
                end
            end else begin
                cnt_reg  <= '0;
                wrap_reg <= 1'b0;
            end
        end
    end

    assign bus.dout  = dout_reg;
    assign bus.ch    = ch_reg;
    assign bus.valid = valid_reg;
    assign bus.wrap  = wrap_reg;
endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed vector table on N=4 and N=3 instances, reset and
// mode corner sequences, then randomized traffic against a behavioural model.
module tb_scan_mux;
    logic clk;
    logic rst_n;

    scan_mux_if #(.N(4), .W(8), .DWELL_W(4)) bus_a ();
    scan_mux_if #(.N(3), .W(8), .DWELL_W(4)) bus_b ();

    scan_mux #(.N(4), .W(8), .DWELL_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    scan_mux #(.N(3), .W(8), .DWELL_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int inst;
        bit en;
        bit mode;
        int sel;
        int dwell;
        int dout;
        int ch;
        bit valid;
        bit wrap;
    } vec_t;

    typedef struct {
        int ptr;
        int elapsed;
        int dout;
        int ch;
        bit valid;
        bit wrap;
    } mstate_t;

    localparam int NVEC = 37;
    vec_t    vecs [NVEC];
    mstate_t ma;
    mstate_t mb;
    int      n_pass;
    int      n_total;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scan behaviour stated directly: each channel owns dwell+1 enabled auto cycles,
    // counted by cycles already spent on it; the pointer walks 0..n-1 cyclically.
    function automatic mstate_t model_next(input mstate_t s, input int n, input bit en,
                                           input bit mode, input int sel, input int dwell,
                                           input logic [31:0] din);
        mstate_t r;
        int c;
        r = s;
        r.wrap = 1'b0;
        if (!en) begin
            r.dout  = 0;
            r.valid = 1'b0;
            return r;
        end
        c = mode ? s.ptr : sel;
        if (c < n) begin
            r.dout  = int'((din >> (8 * c)) & 32'hFF);
            r.ch    = c;
            r.valid = 1'b1;
        end else begin
            r.dout  = 0;
            r.valid = 1'b0;
        end
        if (mode) begin
            if (s.elapsed + 1 > dwell) begin
                r.wrap    = (s.ptr == n - 1);
                r.ptr     = (s.ptr + 1) % n;
                r.elapsed = 0;
            end else begin
                r.elapsed = s.elapsed + 1;
            end
        end else begin
            r.elapsed = 0;
        end
        return r;
    endfunction

    task automatic model_reset();
        ma = '{ptr: 0, elapsed: 0, dout: 0, ch: 0, valid: 1'b0, wrap: 1'b0};
        mb = '{ptr: 0, elapsed: 0, dout: 0, ch: 0, valid: 1'b0, wrap: 1'b0};
    endtask

    task automatic tick();
        @(posedge clk);
        ma = model_next(ma, 4, bus_a.en, bus_a.mode, int'(bus_a.sel), int'(bus_a.dwell), bus_a.din);
        mb = model_next(mb, 3, bus_b.en, bus_b.mode, int'(bus_b.sel), int'(bus_b.dwell),
                        {8'h00, bus_b.din});
        @(negedge clk);
    endtask

    task automatic check_a(input string tag, input int d, input int c, input int v, input int w);
        check({tag, ".a.dout"},  int'(bus_a.dout),  d);
        check({tag, ".a.ch"},    int'(bus_a.ch),    c);
        check({tag, ".a.valid"}, int'(bus_a.valid), v);
        check({tag, ".a.wrap"},  int'(bus_a.wrap),  w);
    endtask

    task automatic apply_vec(input int i);
        vec_t  v;
        string tag;
        int    d, c, vl, w;
        v = vecs[i];
        if (v.inst == 0) begin
            bus_a.en = v.en; bus_a.mode = v.mode;
            bus_a.sel = 2'(v.sel); bus_a.dwell = 4'(v.dwell);
            bus_b.en = 1'b0;
        end else begin
            bus_b.en = v.en; bus_b.mode = v.mode;
            bus_b.sel = 2'(v.sel); bus_b.dwell = 4'(v.dwell);
            bus_a.en = 1'b0;
        end
        tick();
        if (v.inst == 0) begin
            d = int'(bus_a.dout); c = int'(bus_a.ch); vl = int'(bus_a.valid); w = int'(bus_a.wrap);
        end else begin
            d = int'(bus_b.dout); c = int'(bus_b.ch); vl = int'(bus_b.valid); w = int'(bus_b.wrap);
        end
        $display("vec %0d inst%0d en=%0b mode=%0b sel=%0d dwell=%0d -> dout=%02h ch=%0d valid=%0b wrap=%0b",
                 i, v.inst, v.en, v.mode, v.sel, v.dwell, d, c, vl, w);
        tag = $sformatf("v%0d", i);
        check({tag, ".dout"},  d,  v.dout);
        check({tag, ".ch"},    c,  v.ch);
        check({tag, ".valid"}, vl, int'(v.valid));
        check({tag, ".wrap"},  w,  int'(v.wrap));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_reset();

        // N=4: manual sweep, blanking, auto dwell=0
        vecs[0]  = '{0, 1, 0, 0, 0, 'hA0, 0, 1, 0};
        vecs[1]  = '{0, 1, 0, 1, 0, 'hB1, 1, 1, 0};
        vecs[2]  = '{0, 1, 0, 2, 0, 'hC2, 2, 1, 0};
        vecs[3]  = '{0, 1, 0, 3, 0, 'hD3, 3, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 'h00, 3, 0, 0};
        vecs[5]  = '{0, 1, 1, 0, 0, 'hA0, 0, 1, 0};
        vecs[6]  = '{0, 1, 1, 0, 0, 'hB1, 1, 1, 0};
        vecs[7]  = '{0, 1, 1, 0, 0, 'hC2, 2, 1, 0};
        vecs[8]  = '{0, 1, 1, 0, 0, 'hD3, 3, 1, 1};
        vecs[9]  = '{0, 1, 1, 0, 0, 'hA0, 0, 1, 0};
        vecs[10] = '{0, 1, 1, 0, 0, 'hB1, 1, 1, 0};
        // pointer now 2: manual for three cycles, then resume auto at 2
        vecs[11] = '{0, 1, 0, 0, 0, 'hA0, 0, 1, 0};
        vecs[12] = '{0, 1, 0, 1, 0, 'hB1, 1, 1, 0};
        vecs[13] = '{0, 1, 0, 3, 0, 'hD3, 3, 1, 0};
        vecs[14] = '{0, 1, 1, 0, 0, 'hC2, 2, 1, 0};
        vecs[15] = '{0, 0, 1, 0, 0, 'h00, 2, 0, 0};
        // dwell=2 from pointer 3, en dropped mid-dwell on channel 0
        vecs[16] = '{0, 1, 1, 0, 2, 'hD3, 3, 1, 0};
        vecs[17] = '{0, 1, 1, 0, 2, 'hD3, 3, 1, 0};
        vecs[18] = '{0, 1, 1, 0, 2, 'hD3, 3, 1, 1};
        vecs[19] = '{0, 1, 1, 0, 2, 'hA0, 0, 1, 0};
        vecs[20] = '{0, 0, 1, 0, 2, 'h00, 0, 0, 0};
        vecs[21] = '{0, 0, 1, 0, 2, 'h00, 0, 0, 0};
        vecs[22] = '{0, 1, 1, 0, 2, 'hA0, 0, 1, 0};
        vecs[23] = '{0, 1, 1, 0, 2, 'hA0, 0, 1, 0};
        vecs[24] = '{0, 1, 1, 0, 2, 'hB1, 1, 1, 0};
        // dwell raised to 5, then dropped to 1 once the count reaches 3
        vecs[25] = '{0, 1, 1, 0, 5, 'hB1, 1, 1, 0};
        vecs[26] = '{0, 1, 1, 0, 5, 'hB1, 1, 1, 0};
        vecs[27] = '{0, 1, 1, 0, 1, 'hB1, 1, 1, 0};
        vecs[28] = '{0, 1, 1, 0, 1, 'hC2, 2, 1, 0};
        vecs[29] = '{0, 1, 1, 0, 1, 'hC2, 2, 1, 0};
        // N=3: out-of-range select, then auto scan with wrap
        vecs[30] = '{1, 1, 0, 1, 0, 'hB1, 1, 1, 0};
        vecs[31] = '{1, 1, 0, 3, 0, 'h00, 1, 0, 0};
        vecs[32] = '{1, 1, 0, 2, 0, 'hC2, 2, 1, 0};
        vecs[33] = '{1, 1, 1, 0, 0, 'hA0, 0, 1, 0};
        vecs[34] = '{1, 1, 1, 0, 0, 'hB1, 1, 1, 0};
        vecs[35] = '{1, 1, 1, 0, 0, 'hC2, 2, 1, 1};
        vecs[36] = '{1, 1, 1, 0, 0, 'hA0, 0, 1, 0};

        bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.sel = '0; bus_a.dwell = '0;
        bus_a.din = 32'hD3C2B1A0;
        bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.sel = '0; bus_b.dwell = '0;
        bus_b.din = 24'hC2B1A0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset: dout=%02h ch=%0d valid=%0b wrap=%0b", bus_a.dout, bus_a.ch, bus_a.valid, bus_a.wrap);
        check_a("rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) apply_vec(i);

        // Asynchronous reset mid-scan: outputs clear before any clock edge
        bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.dwell = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: dout=%02h ch=%0d valid=%0b wrap=%0b", bus_a.dout, bus_a.ch, bus_a.valid, bus_a.wrap);
        check_a("arst", 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        $display("post-reset 1: dout=%02h ch=%0d", bus_a.dout, bus_a.ch);
        check_a("prst1", 'hA0, 0, 1, 0);
        tick();
        $display("post-reset 2: dout=%02h ch=%0d", bus_a.dout, bus_a.ch);
        check_a("prst2", 'hB1, 1, 1, 0);

        for (int i = 30; i < NVEC; i++) apply_vec(i);

        // Randomized traffic on both instances against the model
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 250; t++) begin
            bus_a.en = ($urandom_range(0, 99) < 85);
            bus_b.en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 7) == 0) bus_a.mode = ~bus_a.mode;
            if ($urandom_range(0, 7) == 0) bus_b.mode = ~bus_b.mode;
            if ($urandom_range(0, 9) == 0) bus_a.dwell = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus_b.dwell = 4'($urandom_range(0, 3));
            bus_a.sel = 2'($urandom_range(0, 3));
            bus_b.sel = 2'($urandom_range(0, 3));
            bus_a.din = $urandom;
            bus_b.din = 24'($urandom);
            tick();
            $display("rnd %0d a: dout=%02h ch=%0d v=%0b w=%0b | b: dout=%02h ch=%0d v=%0b w=%0b",
                     t, bus_a.dout, bus_a.ch, bus_a.valid, bus_a.wrap,
                     bus_b.dout, bus_b.ch, bus_b.valid, bus_b.wrap);
            check("rnd.a.dout",  int'(bus_a.dout),  ma.dout);
            check("rnd.a.ch",    int'(bus_a.ch),    ma.ch);
            check("rnd.a.valid", int'(bus_a.valid), int'(ma.valid));
            check("rnd.a.wrap",  int'(bus_a.wrap),  int'(ma.wrap));
            check("rnd.b.dout",  int'(bus_b.dout),  mb.dout);
            check("rnd.b.ch",    int'(bus_b.ch),    mb.ch);
            check("rnd.b.valid", int'(bus_b.valid), int'(mb.valid));
            check("rnd.b.wrap",  int'(bus_b.wrap),  int'(mb.wrap));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
